vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator: the successor to the fixed 800x600 sync block, and the sole source of sync and pixel-address timing for the display path. It produces HSYNC/VSYNC with programmable porch and sync widths and polarity, plus a pixel-enable input for divided pixel clocks. It also emits line-start and frame-start strobes. Pixel addresses lead the sync/DE outputs by a configurable number of pixel periods, which hides the read latency of a downstream ROM/RAM.

## Interface
- H_SYNC, 128: HSYNC width, pixels
- H_BACK, 88: horizontal back porch
- H_ACTIVE, 800: visible pixels per line
- H_FRONT, 40: horizontal front porch
- V_SYNC, 4: VSYNC width, lines
- V_BACK, 23: vertical back porch
- V_ACTIVE, 600: visible lines
- V_FRONT, 1: vertical front porch
- HS_POL, 0: HSYNC active level
- VS_POL, 0: VSYNC active level
- PIPE_DLY, 1: pixel periods by which sync/DE lag the address outputs (0..4)
- XW, 11 / YW, 10: address widths

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- CE  in  1  pixel enable; all timing advances only on CLK edges with CE=1
- HSYNC_Sig  out  1  horizontal sync
- VSYNC_Sig  out  1  vertical sync
- DE_Sig  out  1  display enable, aligned with sync outputs
- Addr_Valid_Sig  out  1  address outputs refer to a visible pixel
- Column_Addr_Sig  out  XW  x address, 0..H_ACTIVE-1
- Row_Addr_Sig  out  YW  y address, 0..V_ACTIVE-1
- Line_Start_Sig  out  1  one-CLK strobe at the first pixel period of each line
- Frame_Start_Sig  out  1  one-CLK strobe at the first pixel period of each frame

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL likewise. Defaults give 1056 x 628.
- Counters: h runs 0..H_TOTAL-1 and wraps to 0. v increments when h wraps, runs 0..V_TOTAL-1, and wraps to 0 when both wrap together.
- Decode stage (registered, loaded on a CE edge from the current h,v, before the counters advance):
  - hs_act = h < H_SYNC
  - vs_act = v < V_SYNC
  - vis = H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_ACTIVE, and V_SYNC+V_BACK <= v < V_SYNC+V_BACK+V_ACTIVE
- Addr_Valid_Sig = vis. Column = h-(H_SYNC+H_BACK) and Row = v-(V_SYNC+V_BACK) when vis, else 0.
- Line_Start_Sig = 1 for exactly one CLK when the decode stage loads h=0. Frame_Start_Sig = 1 when it loads h=0 and v=0. Both strobes are 0 on every CLK with CE=0.
- Delay line: {hs_act, vs_act, vis} pass through PIPE_DLY stages, each advancing only on CE.
  - Outputs: HSYNC_Sig = hs_act_d ? HS_POL : ~HS_POL; VSYNC_Sig is analogous; DE_Sig = vis_d.
  - PIPE_DLY=0: sync/DE come straight from the decode stage.
- CE=0: counters, decode stage and delay line all hold.

## Timing
- Reset values: counters 0, delay line 0, Addr_Valid/DE/strobes 0, addresses 0, HSYNC=~HS_POL, VSYNC=~VS_POL.
- Reset is asynchronous. Asserted mid-frame, outputs take reset values immediately. After release, the first CE edge decodes (0,0): Frame_Start and Line_Start pulse and HSYNC/VSYNC go active (PIPE_DLY=0).
- With CE=1 constantly, the nth CLK edge after release decodes h=n-1.
- Address-to-DE latency is exactly PIPE_DLY CE edges. Decode latency from counter to output is 1 CE edge.
- Sync-to-sync period is H_TOTAL CE edges (line) and H_TOTAL*V_TOTAL CE edges (frame).
- Porch/sync parameters of 0 are legal except H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC, which must be at least 1.
- Address arithmetic is done at counter width and then truncated to XW/YW. The package checks H_ACTIVE <= 2^XW.

## Structure
- Package vga_timing_pkg:
  - default mode constants (800x600@72, 640x480@60)
  - function computing counter width from H_TOTAL/V_TOTAL
  - sync-polarity constants
- Sub-module vga_delay_line (parameter DEPTH, WIDTH): CE-qualified shift register with an async reset and a DEPTH=0 bypass. Used here with WIDTH=3.

## Test plan
- Reset, then CE=1, defaults → HSYNC_Sig low for the first 128 CLKs, high for 928; the next low edge comes 1056 CLKs after the first.
- First visible pixel → Addr_Valid rises on decode of (216,27) with Col=0, Row=0, and DE_Sig rises 1 CLK later. The last pixel is Col=799, Row=599 at (1015,626). Addr_Valid falls at h=1016.
- Full frame → VSYNC low for 4224 CLKs; Frame_Start spacing 663168 CLKs; 628 Line_Start pulses per frame; exactly 480000 DE-high cycles per frame.
- CE toggling 1,0,1,0 → every period doubles; strobes stay exactly one CLK wide; outputs are stable across CE=0 cycles.
- RST asserted while Col=400 → all outputs at reset values before the next edge. After release, the timing restarts at (0,0) with a Frame_Start pulse.
- Mode 640x480 (H 96/48/640/16, V 2/33/480/10, PIPE_DLY=3, HS_POL=VS_POL=0) → line period 800, frame 525 lines, DE lagging Addr_Valid by 3 CLKs, Col reaching a maximum of 639.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared mode constants, polarity constants and width helpers for the VGA timing generator
package vga_timing_pkg;
  localparam logic POL_NEG = 1'b0;
  localparam logic POL_POS = 1'b1;
  localparam int SVGA_H_SYNC = 128;
  localparam int SVGA_H_BACK = 88;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FRONT = 40;
  localparam int SVGA_V_SYNC = 4;
  localparam int SVGA_V_BACK = 23;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FRONT = 1;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_BACK = 48;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT = 16;
  localparam int VGA_V_SYNC = 2;
  localparam int VGA_V_BACK = 33;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT = 10;
  // wide enough to hold the total itself, so end-of-region bounds never wrap
  function automatic int cnt_width(input int total);
    return (total < 2) ? 1 : $clog2(total + 1);
  endfunction
  function automatic bit addr_fits(input int active, input int w);
    return active <= (1 << w);
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: CE-qualified shift register with async reset and a zero-depth bypass
module vga_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];
    // shift one stage per pixel period, hold otherwise
    always_comb begin
      sr_d = sr_q;
      sr_d[0] = ce ? din : sr_q[0];
      for (int i = 1; i < DEPTH; i++) sr_d[i] = ce ? sr_q[i-1] : sr_q[i];
    end
    // stage registers
    always_ff @(posedge clk or posedge rst)
      if (rst) sr_q <= '{default: '0};
      else sr_q <= sr_d;
    assign dout = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel addresses leading sync/DE by PIPE_DLY pixels
module vga_timing_gen import vga_timing_pkg::*; #(
  parameter int   H_SYNC   = SVGA_H_SYNC,
  parameter int   H_BACK   = SVGA_H_BACK,
  parameter int   H_ACTIVE = SVGA_H_ACTIVE,
  parameter int   H_FRONT  = SVGA_H_FRONT,
  parameter int   V_SYNC   = SVGA_V_SYNC,
  parameter int   V_BACK   = SVGA_V_BACK,
  parameter int   V_ACTIVE = SVGA_V_ACTIVE,
  parameter int   V_FRONT  = SVGA_V_FRONT,
  parameter logic HS_POL   = POL_NEG,
  parameter logic VS_POL   = POL_NEG,
  parameter int   PIPE_DLY = 1,
  parameter int   XW       = 11,
  parameter int   YW       = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  output logic          HSYNC_Sig,
  output logic          VSYNC_Sig,
  output logic          DE_Sig,
  output logic          Addr_Valid_Sig,
  output logic [XW-1:0] Column_Addr_Sig,
  output logic [YW-1:0] Row_Addr_Sig,
  output logic          Line_Start_Sig,
  output logic          Frame_Start_Sig
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SE   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_VS   = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_VE   = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SE   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_VS   = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_VE   = VW'(V_SYNC + V_BACK + V_ACTIVE);
  if (!addr_fits(H_ACTIVE, XW)) begin : g_xw_chk
    $error("H_ACTIVE does not fit in XW address bits");
  end
  if (!addr_fits(V_ACTIVE, YW)) begin : g_yw_chk
    $error("V_ACTIVE does not fit in YW address bits");
  end
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic hs_q, hs_d, vs_q, vs_d, vis_q, vis_d, ls_q, ls_d, fs_q, fs_d;
  logic h_wrap, v_wrap, vis_c;
  logic [2:0] dly;
  // advance the raster position and decode the position being left behind
  always_comb begin
    h_wrap = h_q == H_LAST;
    v_wrap = v_q == V_LAST;
    vis_c = h_q >= H_VS && h_q < H_VE && v_q >= V_VS && v_q < V_VE;
    h_d = CE ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
    v_d = (CE && h_wrap) ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
    hs_d = CE ? h_q < H_SE : hs_q;
    vs_d = CE ? v_q < V_SE : vs_q;
    vis_d = CE ? vis_c : vis_q;
    col_d = CE ? (vis_c ? XW'(h_q - H_VS) : '0) : col_q;
    row_d = CE ? (vis_c ? YW'(v_q - V_VS) : '0) : row_q;
    ls_d = CE && h_q == '0;
    fs_d = CE && h_q == '0 && v_q == '0;
  end
  // counter and decode registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      h_q <= '0;
      v_q <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      vis_q <= 1'b0;
      col_q <= '0;
      row_q <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      vis_q <= vis_d;
      col_q <= col_d;
      row_q <= row_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  vga_delay_line #(.DEPTH(PIPE_DLY), .WIDTH(3)) u_dly (
    .clk(CLK), .rst(RST), .ce(CE), .din({hs_q, vs_q, vis_q}), .dout(dly)
  );
  assign HSYNC_Sig = dly[2] ? HS_POL : ~HS_POL;
  assign VSYNC_Sig = dly[1] ? VS_POL : ~VS_POL;
  assign DE_Sig = dly[0];
  assign Addr_Valid_Sig = vis_q;
  assign Column_Addr_Sig = col_q;
  assign Row_Addr_Sig = row_q;
  assign Line_Start_Sig = ls_q;
  assign Frame_Start_Sig = fs_q;
endmodule
